// File: rtl/fft_cbfp_pkg.sv
// Shared definitions for the CBFP normalisation stage.
//   cbfp_cnt_w : width of a beat counter for a block of n beats (at least 1)
//   bank_t     : ping-pong bank pointer
//   beat_t     : beat counter type for the default block depth
//   round_ofs  : round-half-up offset added before a right shift by sh bits
//   rsb        : redundant sign bits of the low w bits of x
package fft_cbfp_pkg;

  localparam int CBFP_BLOCK_BEATS = 4;

  function automatic int cbfp_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic bank_t;
  typedef logic [cbfp_cnt_w(CBFP_BLOCK_BEATS)-1:0] beat_t;

  function automatic int round_ofs(input int sh);
    return (sh > 0) ? (1 << (sh - 1)) : 0;
  endfunction

  // Number of bits below the MSB that repeat it, for a w-bit value held in
  // the low bits of x. Zero and minus one both give w-1.
  function automatic int unsigned rsb(input logic [63:0] x, input int w);
    int unsigned cnt;
    logic        done;
    logic        msb;
    cnt  = 0;
    done = 1'b0;
    msb  = x[w-1];
    for (int i = 62; i >= 0; i--) begin
      if ((i < w - 1) && !done) begin
        if (x[i] == msb) cnt++;
        else             done = 1'b1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fft_cbfp_min_rsb.sv
// cbfp_min_rsb: combinational minimum of the redundant-sign-bit count over N
// signed samples of width W, reduced with a balanced binary tree. The leaf
// level is padded to a power of two with W-1, the neutral value for min.
//   samples : N packed signed samples, sample i at [i*W +: W]
//   min_r   : smallest redundant-sign-bit count among them
module cbfp_min_rsb
  import fft_cbfp_pkg::*;
#(
  parameter int N     = 32,
  parameter int W     = 13,
  parameter int IDX_W = 5
) (
  input  logic [N*W-1:0]   samples,
  output logic [IDX_W-1:0] min_r
);

  localparam int LVLS = (N > 1) ? $clog2(N) : 0;
  localparam int P    = 1 << LVLS;

  for (genvar l = 0; l <= LVLS; l++) begin : lvl
    localparam int CNT = P >> l;
    logic [IDX_W-1:0] v [CNT];
    for (genvar i = 0; i < CNT; i++) begin : node
      if (l == 0) begin : leaf
        if (i < N) begin : real_leaf
          assign v[i] = IDX_W'(rsb(64'($signed(samples[i*W +: W])), W));
        end else begin : pad_leaf
          assign v[i] = IDX_W'(W - 1);
        end
      end else begin : inner
        assign v[i] = (lvl[l-1].v[2*i] < lvl[l-1].v[2*i+1]) ?
                      lvl[l-1].v[2*i] : lvl[l-1].v[2*i+1];
      end
    end
  end

  assign min_r = lvl[LVLS].v[0];

endmodule

// File: rtl/fft_cbfp_stage.sv
// fft_cbfp_stage: convolutional block-floating-point normalisation stage.
// Buffers blocks of BLOCK_BEATS beats of LANES complex samples in a two-bank
// ping-pong store, finds the block-wide common shift s (minimum redundant sign
// bits), and re-emits each block as (x <<< s) >>> (IN_W-OUT_W) with out_idx=s.
// Optional build macro FFT_CBFP_ROUND_EN: round half up and saturate instead
// of truncating.
//   clk, rstn            : clock; asynchronous reset, active-high
//   in_valid/in_ready    : input handshake, in_re/in_im packed LANES x IN_W
//   out_valid/out_ready  : output handshake, out_re/out_im packed LANES x OUT_W
//   out_idx              : block shift, constant over a block
//   out_last             : final beat of a block
module fft_cbfp_stage
  import fft_cbfp_pkg::*;
#(
  parameter int LANES       = 16,
  parameter int IN_W        = 13,
  parameter int OUT_W       = 11,
  parameter int BLOCK_BEATS = 4,
  parameter int IDX_W       = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_re,
  input  logic [LANES*IN_W-1:0]  in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_re,
  output logic [LANES*OUT_W-1:0] out_im,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last
);

  localparam int                BEAT_W    = cbfp_cnt_w(BLOCK_BEATS);
  localparam int                SH        = IN_W - OUT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_BEATS - 1);
  localparam logic [IDX_W-1:0]  MIN_INIT  = IDX_W'(IN_W - 1);

`ifdef FFT_CBFP_ROUND_EN
  localparam int ROUND_OFS = round_ofs(SH);

  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [IN_W-1:0] n);
    logic signed [IN_W:0] t;
    logic signed [IN_W:0] q;
    logic signed [IN_W:0] hi;
    logic signed [IN_W:0] lo;
    hi = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    lo = -hi - 1;
    t  = (IN_W+1)'(n) + (IN_W+1)'(ROUND_OFS);
    q  = t >>> SH;
    if (q > hi)      return hi[OUT_W-1:0];
    else if (q < lo) return lo[OUT_W-1:0];
    else             return q[OUT_W-1:0];
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] trunc(input logic signed [IN_W-1:0] n);
    return n[IN_W-1 -: OUT_W];
  endfunction
`endif

  // The left shift cannot overflow because s never exceeds the redundant
  // sign bits of any sample in the block.
  function automatic logic signed [OUT_W-1:0] scale(input logic signed [IN_W-1:0] x,
                                                    input logic [IDX_W-1:0] s);
    logic signed [IN_W-1:0] n;
    n = x <<< s;
`ifdef FFT_CBFP_ROUND_EN
    return round_sat(n);
`else
    return trunc(n);
`endif
  endfunction

  // Control state
  bank_t             wr_bank;
  bank_t             rd_bank;
  logic [BEAT_W-1:0] wr_beat;
  logic [BEAT_W-1:0] rd_beat;
  logic [IDX_W-1:0]  run_min;
  logic [1:0]        full;

  // Data store (no reset; reads are gated by the full flags)
  logic [LANES*IN_W-1:0] mem_re [2][BLOCK_BEATS];
  logic [LANES*IN_W-1:0] mem_im [2][BLOCK_BEATS];
  logic [IDX_W-1:0]      s_bank [2];

  logic             accept;
  logic             drain;
  logic             wr_last;
  logic             rd_last;
  logic [IDX_W-1:0] beat_min;
  logic [IDX_W-1:0] new_min;

  cbfp_min_rsb #(
    .N     (2 * LANES),
    .W     (IN_W),
    .IDX_W (IDX_W)
  ) u_min (
    .samples ({in_im, in_re}),
    .min_r   (beat_min)
  );

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign wr_last   = (wr_beat == LAST_BEAT);
  assign rd_last   = (rd_beat == LAST_BEAT);
  assign new_min   = (beat_min < run_min) ? beat_min : run_min;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_bank <= 1'b0;
      wr_beat <= '0;
      run_min <= MIN_INIT;
      rd_bank <= 1'b0;
      rd_beat <= '0;
      full    <= '0;
    end else begin
      if (accept) begin
        if (wr_last) begin
          wr_beat       <= '0;
          run_min       <= MIN_INIT;
          wr_bank       <= ~wr_bank;
          full[wr_bank] <= 1'b1;
        end else begin
          wr_beat <= wr_beat + 1'b1;
          run_min <= new_min;
        end
      end
      // A bank can only be filling or draining, never both, so these two
      // flag updates never target the same bit.
      if (drain) begin
        if (rd_last) begin
          rd_beat       <= '0;
          rd_bank       <= ~rd_bank;
          full[rd_bank] <= 1'b0;
        end else begin
          rd_beat <= rd_beat + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[wr_bank][wr_beat] <= in_re;
      mem_im[wr_bank][wr_beat] <= in_im;
      if (wr_last) s_bank[wr_bank] <= new_min;
    end
  end

  // Read side: combinational scaling of the presented beat
  logic [LANES*IN_W-1:0] rd_re;
  logic [LANES*IN_W-1:0] rd_im;
  logic [IDX_W-1:0]      rd_idx;

  assign rd_re  = mem_re[rd_bank][rd_beat];
  assign rd_im  = mem_im[rd_bank][rd_beat];
  assign rd_idx = s_bank[rd_bank];

  for (genvar l = 0; l < LANES; l++) begin : lane
    assign out_re[l*OUT_W +: OUT_W] = out_valid ? scale(rd_re[l*IN_W +: IN_W], rd_idx) : '0;
    assign out_im[l*OUT_W +: OUT_W] = out_valid ? scale(rd_im[l*IN_W +: IN_W], rd_idx) : '0;
  end

  assign out_idx  = out_valid ? rd_idx : '0;
  assign out_last = out_valid && rd_last;

endmodule
